// File: rtl/audio_eq_pkg.sv
// Constants and sample type shared by the equalizer FIR and the I2S output stage.
package audio_eq_pkg;
  localparam int SAMPLE_W = 24;
  localparam int SLOT_W   = 32;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/audio_i2s_clkgen.sv
// I2S timing: BCLK divider, bit position counter, falling-edge and frame-start strobes.
// Strobes are combinational and mark the clk whose edge drops BCLK; no backpressure.
module audio_i2s_clkgen #(
  parameter int CLK_DIV = 4,
  parameter int SLOT_W  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          o_bclk,
  output logic                          o_fall,
  output logic                          o_load,
  output logic [$clog2(2*SLOT_W)-1:0]   o_bit_nxt
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(2*SLOT_W);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2*SLOT_W-1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [BIT_W-1:0] r_bit_cnt;
  logic             r_bclk;
  logic             w_tc;

  assign w_tc      = (r_div_cnt == DIV_W'(CLK_DIV-1));
  assign o_bclk    = r_bclk;
  assign o_fall    = w_tc & r_bclk;
  assign o_load    = o_fall & (r_bit_cnt == BIT_LAST);
  assign o_bit_nxt = (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + 1'b1;

  // bit_cnt resets to its last value so the first falling edge starts a frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
      r_bit_cnt <= BIT_LAST;
    end else begin
      r_div_cnt <= w_tc ? '0 : r_div_cnt + 1'b1;
      if (w_tc)   r_bclk    <= ~r_bclk;
      if (o_fall) r_bit_cnt <= o_bit_nxt;
    end
  end
endmodule

// File: rtl/audio_i2s_tx.sv
// Stereo sample pair -> Philips I2S serializer with a one-frame holding register.
// Accept-to-MSB is one BCLK after the next frame load; in_ready stays low while a pair is held.
module audio_i2s_tx #(
  parameter int CLK_DIV  = 4,
  parameter int SAMPLE_W = audio_eq_pkg::SAMPLE_W,
  parameter int SLOT_W   = audio_eq_pkg::SLOT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] sample_l,
  input  logic signed [SAMPLE_W-1:0] sample_r,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       i2s_bclk,
  output logic                       i2s_lrck,
  output logic                       i2s_sdata,
  output logic                       underrun
);
  localparam int BIT_W = $clog2(2*SLOT_W);
  localparam int IDX_W = $clog2(SAMPLE_W);

  logic signed [SAMPLE_W-1:0] r_hold_l, r_hold_r, r_frm_l, r_frm_r;
  logic                       r_hold_full, r_lrck, r_sdata, r_underrun;
  logic                       w_fall, w_load, w_accept, w_lrck_nxt, w_sdata_nxt;
  logic [BIT_W-1:0]           w_bit_nxt, w_pos;
  logic [IDX_W-1:0]           w_idx;
  logic signed [SAMPLE_W-1:0] w_word;

  audio_i2s_clkgen #(.CLK_DIV(CLK_DIV), .SLOT_W(SLOT_W)) u_clkgen (
    .clk       (clk),
    .rst       (reset),
    .o_bclk    (i2s_bclk),
    .o_fall    (w_fall),
    .o_load    (w_load),
    .o_bit_nxt (w_bit_nxt)
  );

  assign in_ready  = ~r_hold_full;
  assign w_accept  = in_valid & ~r_hold_full;
  assign i2s_lrck  = r_lrck;
  assign i2s_sdata = r_sdata;
  assign underrun  = r_underrun;

  // Data for the slot position being entered; p=0 is the Philips one-BCLK delay bit
  always_comb begin
    w_lrck_nxt  = (w_bit_nxt >= BIT_W'(SLOT_W));
    w_pos       = w_lrck_nxt ? w_bit_nxt - BIT_W'(SLOT_W) : w_bit_nxt;
    w_word      = w_lrck_nxt ? r_frm_r : r_frm_l;
    w_idx       = IDX_W'(SAMPLE_W) - w_pos[IDX_W-1:0];
    w_sdata_nxt = 1'b0;
    if ((w_pos != '0) && (w_pos <= BIT_W'(SAMPLE_W)))
      w_sdata_nxt = w_word[w_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold_l    <= '0;
      r_hold_r    <= '0;
      r_hold_full <= 1'b0;
      r_frm_l     <= '0;
      r_frm_r     <= '0;
      r_lrck      <= 1'b0;
      r_sdata     <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hold_l <= sample_l;
        r_hold_r <= sample_r;
      end
      r_hold_full <= w_accept | (r_hold_full & ~w_load);
      if (w_load) begin
        r_frm_l <= r_hold_full ? r_hold_l : '0;
        r_frm_r <= r_hold_full ? r_hold_r : '0;
      end
      r_underrun <= w_load & ~r_hold_full;
      if (w_fall) begin
        r_lrck  <= w_lrck_nxt;
        r_sdata <= w_sdata_nxt;
      end
    end
  end
endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx at CLK_DIV=2: outputs are predicted each clk from elapsed time and
// a frame-level record of which pair (or zero) each load picked up.
`timescale 1ns/1ps
module tb_audio_i2s_tx;
  import audio_eq_pkg::*;

  localparam int CLK_DIV   = 2;
  localparam int FRAME_CLK = 2*CLK_DIV*2*SLOT_W;
  localparam int LOAD_PH   = 2*CLK_DIV;

  logic    clk = 1'b0;
  logic    reset = 1'b1;
  sample_t sample_l = '0;
  sample_t sample_r = '0;
  logic    in_valid = 1'b0;
  logic    in_ready, i2s_bclk, i2s_lrck, i2s_sdata, underrun;
  logic [4:0] obs;

  int total = 0;
  int bad   = 0;

  audio_i2s_tx #(.CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .sample_l  (sample_l),
    .sample_r  (sample_r),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .i2s_bclk  (i2s_bclk),
    .i2s_lrck  (i2s_lrck),
    .i2s_sdata (i2s_sdata),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;
  assign obs = {i2s_bclk, i2s_lrck, i2s_sdata, underrun, in_ready};

  // Reference: clks since reset release, holding state, and the content of each frame sent
  int      cyc = 0;
  int      n_acc = 0;
  bit      m_full = 1'b0;
  bit      m_ld, m_acc;
  sample_t m_hold_l, m_hold_r;
  sample_t fl[$];
  sample_t fr[$];
  bit      fu[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc = 0;
      m_full = 1'b0;
      fl.delete();
      fr.delete();
      fu.delete();
    end else begin
      cyc++;
      m_ld  = (cyc % FRAME_CLK) == LOAD_PH;
      m_acc = in_valid && !m_full;
      if (m_ld) begin
        fl.push_back(m_full ? m_hold_l : '0);
        fr.push_back(m_full ? m_hold_r : '0);
        fu.push_back(!m_full);
      end
      if (m_acc) begin
        m_hold_l = sample_l;
        m_hold_r = sample_r;
        n_acc++;
      end
      m_full = m_acc || (m_full && !m_ld);
    end
  end

  function automatic logic [4:0] expect_now();
    int f, b, fn, p;
    logic bc, lr, sd, ur;
    sample_t w;
    bc = ((cyc / CLK_DIV) % 2) == 1;
    f  = cyc / (2*CLK_DIV);
    lr = 1'b0; sd = 1'b0; ur = 1'b0;
    if (f > 0) begin
      b  = (f-1) % (2*SLOT_W);
      fn = (f-1) / (2*SLOT_W);
      lr = (b >= SLOT_W);
      p  = b % SLOT_W;
      if (fn < fl.size()) begin
        w = lr ? fr[fn] : fl[fn];
        if (p >= 1 && p <= SAMPLE_W) sd = w[SAMPLE_W-p];
        ur = ((cyc % FRAME_CLK) == LOAD_PH) && fu[fn];
      end
    end
    return {bc, lr, sd, ur, ~m_full};
  endfunction

  task automatic tick(input logic v, input sample_t l, input sample_t r);
    in_valid = v;
    sample_l = l;
    sample_r = r;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    in_valid = 1'b0;
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] e;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (obs !== 5'b00001) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=00001", i, obs);
      end
    end
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick(1'b0, '0, '0);
      e = expect_now();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL reset_release cyc=%0d got=%b exp=%b", cyc, obs, e);
      end
      if (i == 2 || i == 4) begin
        total++;
        if (i2s_bclk !== (i == 2) || i2s_lrck !== 1'b0) begin
          bad++;
          $display("FAIL first_edge cyc=%0d bclk=%b lrck=%b", cyc, i2s_bclk, i2s_lrck);
        end
      end
    end
  endtask

  task automatic test_single_frame();
    logic [63:0] bits;
    int lr_hi, pad, k;
    sample_t rx_l, rx_r;
    logic [4:0] e;
    bits = '0; lr_hi = 0; pad = 0; rx_l = '0; rx_r = '0;
    do_reset(3);
    for (int i = 0; i < 264; i++) begin
      tick(i == 0, 24'h800001, 24'h7FFFFF);
      e = expect_now();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL single_frame cyc=%0d got=%b exp=%b", cyc, obs, e);
      end
      if (cyc % (2*CLK_DIV) == CLK_DIV && cyc >= 6 && (cyc-6)/4 < 64) begin
        k = (cyc-6)/4;
        bits[k] = i2s_sdata;
        lr_hi += int'(i2s_lrck);
      end
    end
    for (int j = 1; j <= SAMPLE_W; j++) begin
      rx_l[SAMPLE_W-j] = bits[j];
      rx_r[SAMPLE_W-j] = bits[SLOT_W+j];
    end
    for (int j = 0; j < 64; j++)
      if ((j % SLOT_W) == 0 || (j % SLOT_W) > SAMPLE_W) pad += int'(bits[j]);
    total++;
    if (rx_l !== 24'h800001) begin bad++; $display("FAIL sf_left got=%h exp=800001", rx_l); end
    total++;
    if (rx_r !== 24'h7FFFFF) begin bad++; $display("FAIL sf_right got=%h exp=7fffff", rx_r); end
    total++;
    if (lr_hi != SLOT_W) begin bad++; $display("FAIL sf_lrck_high got=%0d exp=%0d", lr_hi, SLOT_W); end
    total++;
    if (pad != 0) begin bad++; $display("FAIL sf_pad_bits got=%0d exp=0", pad); end
  endtask

  task automatic test_underrun();
    int cnt;
    logic [4:0] e;
    cnt = 0;
    repeat (2*FRAME_CLK) begin
      tick(1'b0, '0, '0);
      e = expect_now();
      cnt += int'(underrun);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL underrun cyc=%0d got=%b exp=%b", cyc, obs, e);
      end
    end
    total++;
    if (cnt != 2) begin bad++; $display("FAIL underrun_pulses got=%0d exp=2", cnt); end
  endtask

  task automatic test_back_to_back();
    int unsigned base;
    int a0, dut_acc;
    sample_t l;
    logic [4:0] e;
    base = $urandom;
    a0 = n_acc;
    dut_acc = 0;
    repeat (4*FRAME_CLK) begin
      l = sample_t'(base + 32'(n_acc));
      if (in_ready === 1'b1) dut_acc++;
      tick(1'b1, l, ~l);
      e = expect_now();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL back_to_back cyc=%0d got=%b exp=%b", cyc, obs, e);
      end
    end
    total++;
    if (dut_acc != n_acc - a0) begin
      bad++;
      $display("FAIL b2b_accepts got=%0d exp=%0d", dut_acc, n_acc - a0);
    end
  endtask

  task automatic test_accept_at_load();
    int guard, ld_cyc, k;
    sample_t rl, rr, rx;
    logic [4:0] e;
    guard = 0;
    rl = sample_t'($urandom);
    rr = sample_t'($urandom);
    rx = '0;
    while (!(!m_full && (cyc % FRAME_CLK) == LOAD_PH - 1) && guard < 3*FRAME_CLK) begin
      tick(1'b0, '0, '0);
      guard++;
    end
    if (guard >= 3*FRAME_CLK) begin
      total++; bad++;
      $display("FAIL aal_align timeout got=%0d exp<%0d", guard, 3*FRAME_CLK);
    end
    tick(1'b1, rl, rr);
    ld_cyc = cyc;
    total++;
    if (underrun !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL aal_load_clk underrun=%b in_ready=%b exp 1,0", underrun, in_ready);
    end
    repeat (2*FRAME_CLK) begin
      tick(1'b0, '0, '0);
      e = expect_now();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL accept_at_load cyc=%0d got=%b exp=%b", cyc, obs, e);
      end
      if (cyc >= ld_cyc + FRAME_CLK + 2 + 4 && (cyc - ld_cyc - FRAME_CLK - 2) % 4 == 0) begin
        k = (cyc - ld_cyc - FRAME_CLK - 2) / 4;
        if (k >= 1 && k <= SAMPLE_W) rx[SAMPLE_W-k] = i2s_sdata;
      end
    end
    total++;
    if (rx !== rl) begin bad++; $display("FAIL aal_next_frame got=%h exp=%h", rx, rl); end
  endtask

  task automatic test_random();
    logic [4:0] e;
    repeat (3*FRAME_CLK) begin
      tick($urandom_range(0, 5) == 0, sample_t'($urandom), sample_t'($urandom));
      e = expect_now();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs, e);
      end
    end
  endtask

  task automatic test_mid_reset();
    int guard, cnt;
    logic [4:0] e;
    guard = 0;
    cnt = 0;
    while ((cyc % FRAME_CLK) != 160 && guard < 2*FRAME_CLK) begin
      tick(1'b0, '0, '0);
      guard++;
    end
    if (guard >= 2*FRAME_CLK) begin
      total++; bad++;
      $display("FAIL mr_align timeout got=%0d exp<%0d", guard, 2*FRAME_CLK);
    end
    tick(1'b1, sample_t'($urandom), sample_t'($urandom));
    repeat (3) tick(1'b0, '0, '0);
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL mr_full in_ready=%b exp=0", in_ready); end
    #2 reset = 1'b1;
    #1;
    total++;
    if (obs !== 5'b00001) begin bad++; $display("FAIL mr_async got=%b exp=00001", obs); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (200) begin
      tick(1'b0, '0, '0);
      e = expect_now();
      cnt += int'(underrun);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL mid_reset cyc=%0d got=%b exp=%b", cyc, obs, e);
      end
    end
    total++;
    if (cnt != 1) begin bad++; $display("FAIL mr_underrun got=%0d exp=1", cnt); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_underrun();
    test_back_to_back();
    test_accept_at_load();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
